i2c_master_ctrl: RTL and testbench

Byte-level I2C master sequencer driving SCL/SDA as open-drain enables. It takes one byte command at a time (START/data/STOP/read flags) from the APB register/FIFO side, which the register write decode feeds. It times each SCL phase from the clkdivhi/clkdivlo registers, shifts data MSB-first, samples ACK or read data, and reports completion for the status register.

---
 rtl/i2c_master_ctrl_pkg.sv | 29 ++
 rtl/i2c_master_ctrl_phase_timer.sv | 40 ++++
 rtl/i2c_master_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_ctrl_pkg.sv
// i2c_master_ctrl_pkg: shared definitions for the byte-level I2C master.
//   - CLKDIV_W_DEFAULT : default width of the SCL high/low divider values
//   - state_t          : sequencer state encoding
//   - is_lo_phase()    : true for states whose phase is timed by clkdivlo
package i2c_master_ctrl_pkg;

    localparam int unsigned CLKDIV_W_DEFAULT = 8;

    typedef enum logic [3:0] {
        StIdle,
        StStartA,
        StBitLo,
        StBitHi,
        StAckLo,
        StAckHi,
        StHold,
        StRstartA,
        StRstartB,
        StStopA,
        StStopB,
        StStopC
    } state_t;

    // SCL-low phases use clkdivlo; every other timed phase uses clkdivhi.
    function automatic logic is_lo_phase(input state_t s);
        return (s == StBitLo) || (s == StAckLo) || (s == StStopA) || (s == StRstartA);
    endfunction

endpackage

// File: rtl/i2c_master_ctrl_phase_timer.sv
// i2c_master_ctrl_phase_timer: down-counter timing one SCL phase.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : high in the first cycle of a phase; samples load_val
//   load_val  : phase length minus 1, in clk cycles
//   expire    : high in the last cycle of the phase (one-cycle pulse)
module i2c_master_ctrl_phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic         running_q;

    // The load cycle is itself the first cycle of the phase, so the counter
    // holds the number of cycles still to go after this one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (load) begin
            cnt_q     <= (load_val == '0) ? '0 : load_val - W'(1);
            running_q <= (load_val != '0);
        end else if (running_q) begin
            if (cnt_q == '0) begin
                running_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - W'(1);
            end
        end
    end

    assign expire = load ? (load_val == '0) : (running_q && (cnt_q == '0));

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-level I2C master sequencer (open-drain SCL/SDA enables).
// Ports:
//   pclk, preset         : clock, synchronous active-high reset
//   ctrlEnable           : 0 aborts to IDLE with both lines released
//   clkdivhi, clkdivlo   : SCL high/low phase length minus 1
//   cmdValid/cmdReady    : command handshake (accepted in IDLE or HOLD)
//   cmdStart/Stop/Read/Ack, txData : command fields
//   sdaIn                : synchronised SDA level
//   sclOe, sdaOe         : 1 = pull line low
//   rxData, nack, done, busy : result and status
module i2c_master_ctrl
    import i2c_master_ctrl_pkg::*;
#(
    parameter int unsigned CLKDIV_W = CLKDIV_W_DEFAULT
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                ctrlEnable,
    input  logic [CLKDIV_W-1:0] clkdivhi,
    input  logic [CLKDIV_W-1:0] clkdivlo,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic                cmdStart,
    input  logic                cmdStop,
    input  logic                cmdRead,
    input  logic                cmdAck,
    input  logic [7:0]          txData,
    input  logic                sdaIn,
    output logic                sclOe,
    output logic                sdaOe,
    output logic [7:0]          rxData,
    output logic                nack,
    output logic                done,
    output logic                busy
);

    state_t        state_q;
    logic          scl_oe_q, sda_oe_q;
    logic          phase_start_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_data_q;
    logic          nack_q;
    logic          cmd_stop_q, cmd_read_q, cmd_ack_q;
    logic          expire;
    logic [CLKDIV_W-1:0] load_val;

    // Divider for the phase currently being entered (sampled only on load).
    assign load_val = is_lo_phase(state_q) ? clkdivlo : clkdivhi;

    i2c_master_ctrl_phase_timer #(
        .W (CLKDIV_W)
    ) u_timer (
        .clk      (pclk),
        .rst      (preset),
        .load     (phase_start_q),
        .load_val (load_val),
        .expire   (expire)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= StIdle;
            scl_oe_q      <= 1'b0;
            sda_oe_q      <= 1'b0;
            phase_start_q <= 1'b0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            nack_q        <= 1'b0;
            cmd_stop_q    <= 1'b0;
            cmd_read_q    <= 1'b0;
            cmd_ack_q     <= 1'b0;
        end else if (!ctrlEnable) begin
            state_q       <= StIdle;
            scl_oe_q      <= 1'b0;
            sda_oe_q      <= 1'b0;
            phase_start_q <= 1'b0;
        end else begin
            phase_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmdValid) begin
                        cmd_stop_q    <= cmdStop;
                        cmd_read_q    <= cmdRead;
                        cmd_ack_q     <= cmdAck;
                        shift_q       <= txData;
                        state_q       <= StStartA;
                        phase_start_q <= 1'b1;
                        scl_oe_q      <= 1'b0;
                        sda_oe_q      <= 1'b1;  // START: SDA falls with SCL high
                    end
                end
                StStartA: begin
                    if (expire) begin
                        state_q       <= StBitLo;
                        phase_start_q <= 1'b1;
                        bit_idx_q     <= 3'd7;
                        scl_oe_q      <= 1'b1;
                        sda_oe_q      <= !cmd_read_q && !shift_q[7];
                    end
                end
                StBitLo: begin
                    if (expire) begin
                        state_q       <= StBitHi;
                        phase_start_q <= 1'b1;
                        scl_oe_q      <= 1'b0;
                    end
                end
                StBitHi: begin
                    if (expire) begin
                        shift_q       <= {shift_q[6:0], sdaIn};
                        phase_start_q <= 1'b1;
                        scl_oe_q      <= 1'b1;
                        if (bit_idx_q == 3'd0) begin
                            state_q  <= StAckLo;
                            sda_oe_q <= cmd_read_q && cmd_ack_q;
                        end else begin
                            state_q   <= StBitLo;
                            bit_idx_q <= bit_idx_q - 3'd1;
                            // shift_q[6] becomes the MSB on this same edge
                            sda_oe_q  <= !cmd_read_q && !shift_q[6];
                        end
                    end
                end
                StAckLo: begin
                    if (expire) begin
                        state_q       <= StAckHi;
                        phase_start_q <= 1'b1;
                        scl_oe_q      <= 1'b0;
                    end
                end
                StAckHi: begin
                    if (expire) begin
                        if (cmd_read_q) begin
                            rx_data_q <= shift_q;
                            nack_q    <= 1'b0;
                        end else begin
                            nack_q    <= sdaIn;
                        end
                        scl_oe_q <= 1'b1;
                        if (cmd_stop_q) begin
                            state_q       <= StStopA;
                            phase_start_q <= 1'b1;
                            sda_oe_q      <= 1'b1;
                        end else begin
                            state_q <= StHold;  // SDA keeps its ACK-phase level
                        end
                    end
                end
                StHold: begin
                    if (cmdValid) begin
                        cmd_stop_q    <= cmdStop;
                        cmd_read_q    <= cmdRead;
                        cmd_ack_q     <= cmdAck;
                        shift_q       <= txData;
                        phase_start_q <= 1'b1;
                        if (cmdStart) begin
                            state_q  <= StRstartA;
                            sda_oe_q <= 1'b0;
                        end else begin
                            state_q   <= StBitLo;
                            bit_idx_q <= 3'd7;
                            sda_oe_q  <= !cmdRead && !txData[7];
                        end
                    end
                end
                StRstartA: begin
                    if (expire) begin
                        state_q       <= StRstartB;
                        phase_start_q <= 1'b1;
                        scl_oe_q      <= 1'b0;
                    end
                end
                StRstartB: begin
                    if (expire) begin
                        state_q       <= StStartA;
                        phase_start_q <= 1'b1;
                        sda_oe_q      <= 1'b1;
                    end
                end
                StStopA: begin
                    if (expire) begin
                        state_q       <= StStopB;
                        phase_start_q <= 1'b1;
                        scl_oe_q      <= 1'b0;
                    end
                end
                StStopB: begin
                    if (expire) begin
                        state_q       <= StStopC;
                        phase_start_q <= 1'b1;
                        sda_oe_q      <= 1'b0;  // STOP: SDA rises with SCL high
                    end
                end
                StStopC: begin
                    if (expire) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    scl_oe_q <= 1'b0;
                    sda_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmdReady = ctrlEnable && !preset && ((state_q == StIdle) || (state_q == StHold));
    // Combinational so it lands in the last ACK_HI cycle; an abort that cycle suppresses it.
    assign done     = (state_q == StAckHi) && expire && ctrlEnable && !preset;
    assign busy     = (state_q != StIdle);
    assign sclOe    = scl_oe_q;
    assign sdaOe    = sda_oe_q;
    assign rxData   = rx_data_q;
    assign nack     = nack_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl. Cycle 0 is the cycle in which a command
// is accepted; outputs are sampled and inputs driven on the falling clock edge.
module tb_i2c_master_ctrl;

    logic       pclk = 1'b0;
    logic       preset, ctrlEnable;
    logic [7:0] clkdivhi, clkdivlo;
    logic       cmdValid, cmdReady, cmdStart, cmdStop, cmdRead, cmdAck;
    logic [7:0] txData;
    logic       sdaIn, sclOe, sdaOe;
    logic [7:0] rxData;
    logic       nack, done, busy;

    int errors = 0;
    int checks = 0;

    logic scl_a   [128];
    logic sda_a   [128];
    logic busy_a  [128];
    logic ready_a [128];
    int   done_first;
    int   done_cnt;

    always #5 pclk = ~pclk;

    i2c_master_ctrl #(
        .CLKDIV_W (8)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .ctrlEnable (ctrlEnable),
        .clkdivhi   (clkdivhi),
        .clkdivlo   (clkdivlo),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdStart   (cmdStart),
        .cmdStop    (cmdStop),
        .cmdRead    (cmdRead),
        .cmdAck     (cmdAck),
        .txData     (txData),
        .sdaIn      (sdaIn),
        .sclOe      (sclOe),
        .sdaOe      (sdaOe),
        .rxData     (rxData),
        .nack       (nack),
        .done       (done),
        .busy       (busy)
    );

    // Present one command at the current falling edge and record ncyc+1 cycles.
    // The slave drives read data / ACK in bit windows starting at cycle 'base'.
    // abort_kind: 0 none, 1 drop ctrlEnable at abort_cyc, 2 pulse preset there.
    task automatic run_xfer(input logic st, input logic sp, input logic rd, input logic ak,
                            input logic [7:0] tx, input logic [7:0] pat, input logic sack,
                            input int lo, input int hi, input int base, input int ncyc,
                            input int abort_cyc, input int abort_kind);
        int   per;
        int   k;
        logic lvl;
        per        = lo + hi + 2;
        clkdivlo   = 8'(lo);
        clkdivhi   = 8'(hi);
        done_first = -1;
        done_cnt   = 0;
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) @(negedge pclk);
            if (c == 0) begin
                cmdValid = 1'b1;
                cmdStart = st;
                cmdStop  = sp;
                cmdRead  = rd;
                cmdAck   = ak;
                txData   = tx;
            end else begin
                cmdValid = 1'b0;
            end
            if (c == abort_cyc && abort_kind == 1) ctrlEnable = 1'b0;
            if (c == abort_cyc && abort_kind == 2) preset = 1'b1;
            if (c == abort_cyc + 2 && abort_kind == 2) preset = 1'b0;
            lvl = 1'b1;
            if (c >= base) begin
                k = (c - base) / per;
                if (rd && k < 8) lvl = pat[7-k];
                else if (!rd && k == 8) lvl = sack;
            end
            sdaIn      = lvl & ~sdaOe;
            scl_a[c]   = sclOe;
            sda_a[c]   = sdaOe;
            busy_a[c]  = busy;
            ready_a[c] = cmdReady;
            if (done === 1'b1) begin
                if (done_first < 0) done_first = c;
                done_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] v;
        preset = 1'b1; ctrlEnable = 1'b1; cmdValid = 1'b0; cmdStart = 1'b0; cmdStop = 1'b0;
        cmdRead = 1'b0; cmdAck = 1'b0; txData = 8'h00; sdaIn = 1'b1;
        clkdivhi = 8'd1; clkdivlo = 8'd1;
        repeat (3) @(negedge pclk);
        v = {sclOe, sdaOe, cmdReady, done, busy, nack, rxData};
        checks++;
        if (v !== 14'd0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0", v);
        end
        preset = 1'b0;
        @(negedge pclk);
        checks++;
        if (cmdReady !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after: got %b want 1", cmdReady);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_write_stop();
        int bad_scl, bad_sda;
        logic [7:0] rec;
        bad_scl = 0; bad_sda = 0; rec = 8'h00;
        @(negedge pclk);
        run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1, 1, 3, 46, -1, 0);
        checks++;
        if (ready_a[0] !== 1'b1) begin
            errors++; $display("FAIL wr_accept_ready: got %b want 1", ready_a[0]);
        end
        checks++;
        if ({scl_a[1], sda_a[1]} !== 2'b01) begin
            errors++; $display("FAIL wr_start_cond: got %b want 01", {scl_a[1], sda_a[1]});
        end
        for (int c = 3; c <= 38; c++) begin
            if (scl_a[c] !== (((c - 3) % 4) < 2)) bad_scl++;
            if (sda_a[c] !== sda_a[3 + ((c - 3) / 4) * 4]) bad_sda++;
        end
        checks++;
        if (bad_scl != 0) begin
            errors++; $display("FAIL wr_scl_pattern: got %0d bad cycles want 0", bad_scl);
        end
        checks++;
        if (bad_sda != 0) begin
            errors++; $display("FAIL wr_sda_stable: got %0d mid-bit changes want 0", bad_sda);
        end
        for (int k = 0; k < 8; k++) rec = {rec[6:0], ~sda_a[3 + 4*k + 2]};
        checks++;
        if (rec !== 8'hA5) begin
            errors++; $display("FAIL wr_sda_bits: got %h want a5", rec);
        end
        checks++;
        if (done_first != 38 || done_cnt != 1) begin
            errors++;
            $display("FAIL wr_done_cycle: got %0d (x%0d) want 38 (x1)", done_first, done_cnt);
        end
        checks++;
        if (nack !== 1'b0) begin
            errors++; $display("FAIL wr_nack: got %b want 0", nack);
        end
        checks++;
        if ({scl_a[39], sda_a[39], scl_a[41], sda_a[41], scl_a[43], sda_a[43]} !== 6'b110100) begin
            errors++;
            $display("FAIL wr_stop_seq: got %b want 110100",
                     {scl_a[39], sda_a[39], scl_a[41], sda_a[41], scl_a[43], sda_a[43]});
        end
        checks++;
        if ({busy_a[44], busy_a[45]} !== 2'b10) begin
            errors++; $display("FAIL wr_idle_time: got %b want 10", {busy_a[44], busy_a[45]});
        end
    endtask

    task automatic test_read();
        int bad;
        bad = 0;
        @(negedge pclk);
        run_xfer(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b1, 1, 1, 3, 46, -1, 0);
        for (int c = 3; c <= 38; c++) if (sda_a[c] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rd_sda_released: got %0d driven cycles want 0", bad);
        end
        checks++;
        if (rxData !== 8'h3C) begin
            errors++; $display("FAIL rd_rxdata: got %h want 3c", rxData);
        end
        checks++;
        if (nack !== 1'b0 || done_first != 38) begin
            errors++; $display("FAIL rd_nack_done: got nack=%b done@%0d want 0 @38", nack, done_first);
        end
    endtask

    task automatic test_write_nack();
        int bad_scl;
        logic [7:0] rec;
        bad_scl = 0; rec = 8'h00;
        @(negedge pclk);
        run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, 2, 1, 3, 56, -1, 0);
        for (int c = 3; c <= 47; c++) if (scl_a[c] !== (((c - 3) % 5) < 3)) bad_scl++;
        for (int k = 0; k < 8; k++) rec = {rec[6:0], ~sda_a[3 + 5*k + 3]};
        checks++;
        if (bad_scl != 0) begin
            errors++; $display("FAIL nk_scl_pattern: got %0d bad cycles want 0", bad_scl);
        end
        checks++;
        if (rec !== 8'h3C) begin
            errors++; $display("FAIL nk_sda_bits: got %h want 3c", rec);
        end
        checks++;
        if (done_first != 47 || nack !== 1'b1) begin
            errors++; $display("FAIL nk_done_nack: got done@%0d nack=%b want @47 1", done_first, nack);
        end
        checks++;
        if ({scl_a[48], sda_a[48], scl_a[51], sda_a[51], scl_a[53], sda_a[53], busy_a[55]}
            !== 7'b1101000) begin
            errors++;
            $display("FAIL nk_stop_seq: got %b want 1101000",
                     {scl_a[48], sda_a[48], scl_a[51], sda_a[51], scl_a[53], sda_a[53], busy_a[55]});
        end
    endtask

    task automatic test_enable_drop();
        @(negedge pclk);
        // Cycle 17 is the first BIT_HI cycle of bit index 4.
        run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1, 1, 3, 45, 17, 1);
        checks++;
        if ({scl_a[17], sda_a[17], scl_a[18], sda_a[18], busy_a[18], ready_a[18]} !== 6'b010000) begin
            errors++;
            $display("FAIL en_release: got %b want 010000",
                     {scl_a[17], sda_a[17], scl_a[18], sda_a[18], busy_a[18], ready_a[18]});
        end
        checks++;
        if (done_cnt != 0) begin
            errors++; $display("FAIL en_no_done: got %0d pulses want 0", done_cnt);
        end
        checks++;
        if (rxData !== 8'h3C || nack !== 1'b1) begin
            errors++; $display("FAIL en_hold_status: got rx=%h nack=%b want 3c 1", rxData, nack);
        end
        ctrlEnable = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge pclk);
        // Cycle 8 is a BIT_LO cycle with SDA pulled low.
        run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1, 1, 3, 30, 8, 2);
        checks++;
        if ({scl_a[8], sda_a[8], scl_a[9], sda_a[9], busy_a[9]} !== 5'b11000) begin
            errors++;
            $display("FAIL rst_release: got %b want 11000",
                     {scl_a[8], sda_a[8], scl_a[9], sda_a[9], busy_a[9]});
        end
        checks++;
        if (done_cnt != 0 || rxData !== 8'h00 || nack !== 1'b0) begin
            errors++;
            $display("FAIL rst_status: got done=%0d rx=%h nack=%b want 0 00 0", done_cnt, rxData, nack);
        end
    endtask

    task automatic test_repeated_start();
        logic [7:0] rec;
        rec = 8'h00;
        @(negedge pclk);
        run_xfer(1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 8'h00, 1'b0, 1, 1, 3, 40, -1, 0);
        checks++;
        if (done_first != 38 || {scl_a[39], scl_a[40], sda_a[40], busy_a[40], ready_a[40]} !== 5'b11011) begin
            errors++;
            $display("FAIL rs_hold: got done@%0d %b want @38 11011", done_first,
                     {scl_a[39], scl_a[40], sda_a[40], busy_a[40], ready_a[40]});
        end
        // Accepted in HOLD: RSTART_A 1-2, RSTART_B 3-4, START_A 5-6, bits from 7.
        run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00, 1'b0, 1, 1, 7, 50, -1, 0);
        checks++;
        if ({scl_a[1], sda_a[1], scl_a[3], sda_a[3], scl_a[5], sda_a[5]} !== 6'b100001) begin
            errors++;
            $display("FAIL rs_sequence: got %b want 100001",
                     {scl_a[1], sda_a[1], scl_a[3], sda_a[3], scl_a[5], sda_a[5]});
        end
        for (int k = 0; k < 8; k++) rec = {rec[6:0], ~sda_a[7 + 4*k + 2]};
        checks++;
        if (rec !== 8'h55) begin
            errors++; $display("FAIL rs_sda_bits: got %h want 55", rec);
        end
        checks++;
        if (done_first != 42 || busy_a[49] !== 1'b0) begin
            errors++;
            $display("FAIL rs_done_idle: got done@%0d busy49=%b want @42 0", done_first, busy_a[49]);
        end
    endtask

    task automatic test_fast();
        int bad_scl;
        logic [7:0] rec;
        bad_scl = 0; rec = 8'h00;
        @(negedge pclk);
        run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 1'b0, 0, 0, 2, 24, -1, 0);
        for (int c = 2; c <= 19; c++) if (scl_a[c] !== (((c - 2) % 2) == 0)) bad_scl++;
        for (int k = 0; k < 8; k++) rec = {rec[6:0], ~sda_a[2 + 2*k + 1]};
        checks++;
        if (bad_scl != 0) begin
            errors++; $display("FAIL fast_scl_pattern: got %0d bad cycles want 0", bad_scl);
        end
        checks++;
        if (rec !== 8'hF0) begin
            errors++; $display("FAIL fast_sda_bits: got %h want f0", rec);
        end
        checks++;
        if (done_first != 19 || done_cnt != 1) begin
            errors++; $display("FAIL fast_done_cycle: got %0d (x%0d) want 19 (x1)", done_first, done_cnt);
        end
        checks++;
        if ({busy_a[22], busy_a[23]} !== 2'b10) begin
            errors++; $display("FAIL fast_idle_time: got %b want 10", {busy_a[22], busy_a[23]});
        end
    endtask

    initial begin
        test_reset();
        test_write_stop();
        test_read();
        test_write_nack();
        test_enable_drop();
        test_reset_mid();
        test_repeated_start();
        test_fast();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
